// File: rtl/dict_value_decompressor.sv
`default_nettype none
// ============================================================================
// Module   : dict_value_decompressor
// Brief    : Rebuilds a serial bitstream from a frame of packed codebook
//            indices. Each index selects a CHUNK_SIZE-bit codeword from a
//            programmable codebook; codewords are emitted MSB first, one bit
//            per clock, with a frame_done pulse on the final bit.
// Revision : 1.0 - initial release
// ============================================================================
module dict_value_decompressor #(
    parameter int CHUNK_SIZE    = 8,
    parameter int CODEBOOK_SIZE = 16,
    parameter int INDEX_BITS    = $clog2(CODEBOOK_SIZE),
    parameter int NUM_CHUNKS    = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cb_wr_en,
    input  logic [INDEX_BITS-1:0]          cb_wr_addr,
    input  logic [CHUNK_SIZE-1:0]          cb_wr_data,
    input  logic [NUM_CHUNKS*INDEX_BITS-1:0] compressed_in,
    input  logic                           compressed_valid,
    output logic                           in_ready,
    output logic                           data_out,
    output logic                           data_out_valid,
    output logic                           frame_done
);

    localparam int c_CHUNK_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int c_BIT_W   = (CHUNK_SIZE > 1) ? $clog2(CHUNK_SIZE) : 1;
    localparam logic [c_CHUNK_W-1:0] c_LAST_CHUNK = c_CHUNK_W'(NUM_CHUNKS - 1);
    localparam logic [c_BIT_W-1:0]   c_LAST_BIT   = c_BIT_W'(CHUNK_SIZE - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t                          r_state;
    state_t                          w_state_next;

    logic [CHUNK_SIZE-1:0]           r_codebook [CODEBOOK_SIZE];
    logic [NUM_CHUNKS*INDEX_BITS-1:0] r_idx;
    logic                            r_valid_prev;
    logic [c_CHUNK_W-1:0]            r_chunk_cnt;
    logic [c_BIT_W-1:0]              r_bit_cnt;
    logic                            r_data_out;
    logic                            r_data_out_valid;
    logic                            r_frame_done;

    logic [c_CHUNK_W-1:0]            w_chunk_next;
    logic [c_BIT_W-1:0]              w_bit_next;
    logic                            w_data_out_next;
    logic                            w_valid_next;
    logic                            w_done_next;

    logic                            w_accept;
    logic                            w_last_bit;
    logic                            w_last_chunk;
    logic [c_CHUNK_W-1:0]            w_nchunk;
    logic [c_BIT_W-1:0]              w_nbit;
    logic                            w_next_is_last;
    logic [INDEX_BITS-1:0]           w_idx_arr [NUM_CHUNKS];
    logic [INDEX_BITS-1:0]           w_lk_idx;
    logic [c_BIT_W-1:0]              w_lk_bitsel;
    logic [CHUNK_SIZE-1:0]           w_word;
    logic                            w_lk_bit;
    logic                            w_wr_ok;
    logic                            w_rd_ok;

    // Chunk 0 sits in the most significant INDEX_BITS of the packed vector.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHUNKS; gi++) begin : g_unpack
            assign w_idx_arr[gi] = r_idx[(NUM_CHUNKS-1-gi)*INDEX_BITS +: INDEX_BITS];
        end
    endgenerate

    // Out-of-range addresses only exist when the codebook is not a power of two.
    generate
        if (CODEBOOK_SIZE == (1 << INDEX_BITS)) begin : g_pow2
            assign w_wr_ok = 1'b1;
            assign w_rd_ok = 1'b1;
        end else begin : g_npow2
            assign w_wr_ok = ({1'b0, cb_wr_addr} < (INDEX_BITS+1)'(CODEBOOK_SIZE));
            assign w_rd_ok = ({1'b0, w_lk_idx}   < (INDEX_BITS+1)'(CODEBOOK_SIZE));
        end
    endgenerate

    assign w_accept       = (r_state == S_IDLE) && compressed_valid && !r_valid_prev;
    assign w_last_bit     = (r_bit_cnt == c_LAST_BIT);
    assign w_last_chunk   = (r_chunk_cnt == c_LAST_CHUNK);
    assign w_nbit         = w_last_bit ? '0 : r_bit_cnt + 1'b1;
    assign w_nchunk       = w_last_bit ? r_chunk_cnt + 1'b1 : r_chunk_cnt;
    assign w_next_is_last = (w_nchunk == c_LAST_CHUNK) && (w_nbit == c_LAST_BIT);

    // The bit to be shown next cycle is looked up now, so outputs stay
    // registered while the first bit still lands right after the accept cycle.
    assign w_lk_idx    = (r_state == S_IDLE) ? compressed_in[NUM_CHUNKS*INDEX_BITS-1 -: INDEX_BITS]
                                             : w_idx_arr[w_nchunk];
    assign w_lk_bitsel = (r_state == S_IDLE) ? c_LAST_BIT : (c_LAST_BIT - w_nbit);

    // A same-cycle write to the entry being read is forwarded so a write is
    // seen by the very next emitted bit.
    assign w_word   = !w_rd_ok ? '0 :
                      (cb_wr_en && w_wr_ok && (cb_wr_addr == w_lk_idx)) ? cb_wr_data
                                                                        : r_codebook[w_lk_idx];
    assign w_lk_bit = w_word[w_lk_bitsel];

    assign in_ready       = (r_state == S_IDLE);
    assign data_out       = r_data_out;
    assign data_out_valid = r_data_out_valid;
    assign frame_done     = r_frame_done;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        w_state_next    = r_state;
        w_chunk_next    = r_chunk_cnt;
        w_bit_next      = r_bit_cnt;
        w_data_out_next = 1'b0;
        w_valid_next    = 1'b0;
        w_done_next     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next    = S_EMIT;
                    w_chunk_next    = '0;
                    w_bit_next      = '0;
                    w_data_out_next = w_lk_bit;
                    w_valid_next    = 1'b1;
                end
            end
            S_EMIT: begin
                if (w_last_bit && w_last_chunk) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_chunk_next    = w_nchunk;
                    w_bit_next      = w_nbit;
                    w_data_out_next = w_lk_bit;
                    w_valid_next    = 1'b1;
                    w_done_next     = w_next_is_last;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Counters, registered outputs, index capture and valid edge tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx            <= '0;
            r_valid_prev     <= 1'b0;
            r_chunk_cnt      <= '0;
            r_bit_cnt        <= '0;
            r_data_out       <= 1'b0;
            r_data_out_valid <= 1'b0;
            r_frame_done     <= 1'b0;
        end else begin
            r_valid_prev     <= compressed_valid;
            r_chunk_cnt      <= w_chunk_next;
            r_bit_cnt        <= w_bit_next;
            r_data_out       <= w_data_out_next;
            r_data_out_valid <= w_valid_next;
            r_frame_done     <= w_done_next;
            if (w_accept) begin
                r_idx <= compressed_in;
            end
        end
    end

    // Codebook register file, writable in any state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CODEBOOK_SIZE; i++) begin
                r_codebook[i] <= '0;
            end
        end else if (cb_wr_en && w_wr_ok) begin
            r_codebook[cb_wr_addr] <= cb_wr_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dict_value_decompressor.sv
`default_nettype none
// ============================================================================
// Module   : tb_dict_value_decompressor
// Brief    : Scoreboard bench for dict_value_decompressor. Stimulus pushes the
//            expected bit sequence of each frame; a negedge monitor pops and
//            compares whenever data_out_valid is high.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dict_value_decompressor;

    localparam int CHUNK_SIZE    = 8;
    localparam int CODEBOOK_SIZE = 16;
    localparam int INDEX_BITS    = 4;
    localparam int NUM_CHUNKS    = 16;
    localparam int FRAME_BITS    = NUM_CHUNKS * CHUNK_SIZE;

    logic                            clk = 1'b0;
    logic                            rst = 1'b1;
    logic                            cb_wr_en = 1'b0;
    logic [INDEX_BITS-1:0]           cb_wr_addr = '0;
    logic [CHUNK_SIZE-1:0]           cb_wr_data = '0;
    logic [NUM_CHUNKS*INDEX_BITS-1:0] compressed_in = '0;
    logic                            compressed_valid = 1'b0;
    logic                            in_ready;
    logic                            data_out;
    logic                            data_out_valid;
    logic                            frame_done;

    dict_value_decompressor #(
        .CHUNK_SIZE    (CHUNK_SIZE),
        .CODEBOOK_SIZE (CODEBOOK_SIZE),
        .INDEX_BITS    (INDEX_BITS),
        .NUM_CHUNKS    (NUM_CHUNKS)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .cb_wr_en         (cb_wr_en),
        .cb_wr_addr       (cb_wr_addr),
        .cb_wr_data       (cb_wr_data),
        .compressed_in    (compressed_in),
        .compressed_valid (compressed_valid),
        .in_ready         (in_ready),
        .data_out         (data_out),
        .data_out_valid   (data_out_valid),
        .frame_done       (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic b;
        logic last;
    } exp_t;

    exp_t            exp_q [$];
    logic [7:0]      cb_model [CODEBOOK_SIZE];
    int              checks = 0;
    int              errors = 0;
    int              cyc = 0;
    int              frame_bits = 0;
    int              bits_total = 0;
    int              done_cnt = 0;
    int              first_bit_cyc = 0;
    int              last_done_cyc = 0;
    int              gap = 0;
    int              raise_cyc = 0;
    bit              in_frame = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every valid bit against the scoreboard and flags bubbles.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            in_frame   = 1'b0;
            frame_bits = 0;
        end else if (data_out_valid) begin
            if (!in_frame) begin
                first_bit_cyc = cyc;
                gap           = cyc - last_done_cyc;
                in_frame      = 1'b1;
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_bit: data_out_valid=1 with empty scoreboard at cycle %0d", cyc);
            end else begin
                e = exp_q.pop_front();
                if (data_out !== e.b || frame_done !== e.last) begin
                    errors++;
                    $display("FAIL bit_%0d: got data_out=%b frame_done=%b, want %b %b",
                             frame_bits, data_out, frame_done, e.b, e.last);
                end
            end
            frame_bits++;
            bits_total++;
            if (frame_done) begin
                done_cnt++;
                last_done_cyc = cyc;
                in_frame      = 1'b0;
                frame_bits    = 0;
            end
        end else begin
            checks++;
            if (in_frame) begin
                errors++;
                $display("FAIL bubble: valid dropped after %0d bits, want contiguous frame", frame_bits);
                in_frame = 1'b0;
            end else if (frame_done !== 1'b0 || data_out !== 1'b0) begin
                errors++;
                $display("FAIL idle_outputs: got data_out=%b frame_done=%b, want 0 0",
                         data_out, frame_done);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, want);
        end
    endtask

    task automatic cb_write(input logic [3:0] addr, input logic [7:0] data);
        cb_wr_en   = 1'b1;
        cb_wr_addr = addr;
        cb_wr_data = data;
        cb_model[addr] = data;
        tick();
        cb_wr_en = 1'b0;
    endtask

    // Reference: the frame is the concatenation of codebook[index] words, MSB first.
    task automatic push_frame(input logic [63:0] idx);
        exp_t       e;
        logic [3:0] k;
        logic [7:0] code;
        for (int c = 0; c < NUM_CHUNKS; c++) begin
            k    = idx[63 - 4*c -: 4];
            code = cb_model[k];
            for (int b = 0; b < CHUNK_SIZE; b++) begin
                e.b    = code[CHUNK_SIZE-1-b];
                e.last = (c == NUM_CHUNKS-1) && (b == CHUNK_SIZE-1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic start_frame(input logic [63:0] idx);
        push_frame(idx);
        compressed_in    = idx;
        compressed_valid = 1'b1;
        raise_cyc        = cyc;
    endtask

    task automatic wait_frame_bits(input int n);
        int budget = 400;
        while (frame_bits < n && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) begin
            checks++;
            errors++;
            $display("FAIL wait_bits: got %0d bits, want %0d", frame_bits, n);
        end
    endtask

    task automatic wait_done(input int prev);
        int budget = 400;
        while (done_cnt == prev && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) begin
            checks++;
            errors++;
            $display("FAIL wait_done: got %0d frame_done pulses, want %0d", done_cnt, prev + 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         d;
        int         b0;
        logic [63:0] r;

        for (int k = 0; k < CODEBOOK_SIZE; k++) cb_model[k] = 8'h00;

        // Reset state
        tick();
        tick();
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_valid",    {63'd0, data_out_valid}, 64'd0);
        check("rst_data",     {63'd0, data_out}, 64'd0);
        check("rst_done",     {63'd0, frame_done}, 64'd0);
        rst = 1'b0;
        tick();

        for (int k = 0; k < CODEBOOK_SIZE; k++) begin
            logic [3:0] kk;
            kk = 4'(k);
            cb_write(kk, {kk, ~kk});
        end

        // Frame decode while valid is held high for 300 cycles
        d  = done_cnt;
        b0 = bits_total;
        start_frame(64'h0123456789ABCDEF);
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 10) check("emit_in_ready", {63'd0, in_ready}, 64'd0);
        end
        check("held_done_cnt", 64'(done_cnt - d), 64'd1);
        check("held_bits",     64'(bits_total - b0), 64'(FRAME_BITS));
        check("latency",       64'(first_bit_cyc - raise_cyc), 64'd1);
        check("held_q_empty",  64'(exp_q.size()), 64'd0);
        compressed_valid = 1'b0;
        tick();

        // Edge during EMIT is ignored
        d = done_cnt;
        start_frame(64'h0123456789ABCDEF);
        tick();
        wait_frame_bits(50);
        compressed_valid = 1'b0;
        tick();
        compressed_valid = 1'b1;
        compressed_in    = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        check("edge_emit_in_ready", {63'd0, in_ready}, 64'd0);
        wait_done(d);
        check("edge_in_ready_after", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 20; i++) tick();
        check("edge_done_cnt", 64'(done_cnt - d), 64'd1);
        check("edge_q_empty",  64'(exp_q.size()), 64'd0);
        compressed_valid = 1'b0;
        tick();

        // Codebook write mid-frame lands on chunk 10
        d = done_cnt;
        cb_model[10] = 8'hC3;
        start_frame(64'h0123456789ABCDEF);
        tick();
        compressed_valid = 1'b0;
        wait_frame_bits(42);
        cb_write(4'hA, 8'hC3);
        wait_done(d);
        check("cbwr_q_empty", 64'(exp_q.size()), 64'd0);
        tick();

        // Reset mid-frame aborts and clears the codebook
        d = done_cnt;
        r = {$urandom, $urandom};
        start_frame(r);
        tick();
        compressed_valid = 1'b0;
        wait_frame_bits(40);
        rst = 1'b1;
        #1;
        check("rst_mid_valid",    {63'd0, data_out_valid}, 64'd0);
        check("rst_mid_done",     {63'd0, frame_done}, 64'd0);
        check("rst_mid_in_ready", {63'd0, in_ready}, 64'd1);
        exp_q.delete();
        for (int k = 0; k < CODEBOOK_SIZE; k++) cb_model[k] = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_no_done", 64'(done_cnt - d), 64'd0);
        start_frame({$urandom, $urandom});
        tick();
        compressed_valid = 1'b0;
        wait_done(d);
        check("rst_zero_frame_done", 64'(done_cnt - d), 64'd1);
        check("rst_zero_q_empty",    64'(exp_q.size()), 64'd0);
        tick();

        // Reload a random codebook, then back-to-back random frames
        for (int k = 0; k < CODEBOOK_SIZE; k++) cb_write(4'(k), 8'($urandom));
        d = done_cnt;
        start_frame({$urandom, $urandom});
        tick();
        compressed_valid = 1'b0;
        for (int n = 0; n < 5; n++) begin
            wait_done(d);
            d = done_cnt;
            check("b2b_in_ready", {63'd0, in_ready}, 64'd1);
            start_frame({$urandom, $urandom});
            tick();
            compressed_valid = 1'b0;
            tick();
            check("b2b_gap", 64'(gap), 64'd2);
        end
        wait_done(d);
        check("final_q_empty", 64'(exp_q.size()), 64'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dict_value_decompressor.md
Name: dict_value_decompressor

Overview:
- Downstream stage of dict_value_compressor_with_reg.
- Consumes the packed index vector (NUM_CHUNKS indices of INDEX_BITS each) and rebuilds the serial bitstream.
- Looks up each index in a programmable codebook register file and emits the CHUNK_SIZE-bit codeword MSB first, one bit per clock.
- Serves as the reconstruction path for round-trip checking and as the decode side of the link.

Parameters:
- CHUNK_SIZE, 8: bits per codeword / reconstructed chunk.
- CODEBOOK_SIZE, 16: number of codebook entries.
- INDEX_BITS, $clog2(CODEBOOK_SIZE): width of one index.
- NUM_CHUNKS, 16: indices per frame; frame emits NUM_CHUNKS*CHUNK_SIZE bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cb_wr_en  in  1  codebook write strobe.
- cb_wr_addr  in  INDEX_BITS  codebook entry to write.
- cb_wr_data  in  CHUNK_SIZE  codeword to write.
- compressed_in  in  NUM_CHUNKS*INDEX_BITS  packed indices; chunk 0 = MSB INDEX_BITS.
- compressed_valid  in  1  frame available (level, e.g. compression_done).
- in_ready  out  1  high in IDLE; a frame can be accepted.
- data_out  out  1  reconstructed bit.
- data_out_valid  out  1  data_out is valid this cycle.
- frame_done  out  1  one-cycle pulse coincident with last bit of the frame.

Behaviour:
- Reset (async, immediate) values:
  - FSM = IDLE; in_ready=1; data_out=0; data_out_valid=0; frame_done=0.
  - All codebook entries = 0; valid-edge register = 0.
- Frame acceptance:
  - A frame is accepted only on a rising edge of compressed_valid (current=1, registered previous=0) while in IDLE.
  - A level held high never starts a second frame.
  - Edges outside IDLE are ignored, not queued.
  - compressed_valid already high when rst deasserts counts as a rising edge.
- On accept:
  - compressed_in is captured into an internal index register; later changes on compressed_in have no effect on the frame.
  - chunk_cnt=0, bit_cnt=0, FSM -> EMIT.
- FSM: IDLE -> EMIT on accept; EMIT -> IDLE after the last bit. No other states.
- EMIT: outputs are registered.
  - Latency: first bit appears the cycle after the accept cycle.
  - Each cycle: data_out = codebook[idx[chunk_cnt]][CHUNK_SIZE-1-bit_cnt], data_out_valid=1.
  - bit_cnt wraps CHUNK_SIZE-1 -> 0 and increments chunk_cnt.
  - Exactly NUM_CHUNKS*CHUNK_SIZE contiguous valid cycles, no bubbles; in_ready=0 throughout.
- Frame end:
  - frame_done=1 in the same cycle as the final bit (chunk NUM_CHUNKS-1, bit 0).
  - Next cycle: data_out_valid=0, data_out=0, in_ready=1.
- Back-to-back frames: a new rising edge in the first IDLE cycle is accepted, giving exactly one idle output cycle between frames.
- Codebook:
  - Writable in any state; a write in cycle t is visible to reads from cycle t+1.
  - If CODEBOOK_SIZE is not a power of two:
    - Writes with cb_wr_addr >= CODEBOOK_SIZE are ignored.
    - Indices >= CODEBOOK_SIZE decode to all-zero codewords.
- Reset mid-frame: the frame is aborted immediately; no frame_done. The next rising edge of compressed_valid starts from chunk 0.

Test Plan:
- Frame decode:
  - Stimulus: write entry k = {k[3:0], ~k[3:0]} for k=0..15; compressed_in=64'h0123456789ABCDEF; raise compressed_valid.
  - Response: 128 contiguous valid bits starting the cycle after the edge. Chunk 0 = 00001111, chunk 1 = 00011110, ..., chunk 15 = 11110000. frame_done only on bit 128.
- Held valid:
  - Stimulus: hold compressed_valid high for 300 cycles.
  - Response: exactly one 128-bit frame and one frame_done pulse.
- Edge during EMIT:
  - Stimulus: drop, then re-raise compressed_valid at bit 50 with compressed_in=64'hFFFF_FFFF_FFFF_FFFF.
  - Response: ignored; current frame completes unchanged; in_ready=0 until after frame_done.
- Codebook write mid-frame:
  - Stimulus: during chunk 5, write entry 0xA = 8'hC3.
  - Response: chunk 10 emits 11000011.
- Reset mid-frame:
  - Stimulus: assert rst at bit 40.
  - Response: data_out_valid=0 immediately, no frame_done, codebook reads 0. After reload and a new edge, decode restarts at chunk 0.
- Back-to-back frames:
  - Stimulus: rising edge in the cycle after frame_done.
  - Response: accepted; exactly one invalid cycle between the last bit and the next first bit.
